ps2_scancode_decoder: RTL
=========================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes raw bytes from the PS/2 keyboard receiver (8-bit byte + done flag) and decodes
//  scan-code set 2 sequences (make, F0 break, E0 extended, E1 pause) into key events.
//  Keeps a held-key bitmap for the game-control keys and suppresses typematic repeats.
//  Sits between the Keyboard receiver and the game control FSM. Single clock domain, i_clk.
// PARAMETERS
//  TIMEOUT_CYC  500_000  i_clk cycles allowed between prefix byte and following byte (10 ms @50 MHz)
//  E1_SKIP      7        bytes discarded after an E1 prefix (Pause sequence)
// PORTS
//  i_clk        in   1  system clock (50 MHz)
//  i_rst        in   1  synchronous, active-high reset
//  i_byte       in   8  byte from receiver; valid when i_byte_done rises
//  i_byte_done  in   1  receiver done flag; level, may stay high many cycles
//  o_evt_valid  out  1  one-cycle pulse: new key event on o_evt_*
//  o_evt_code   out  8  scan code (prefixes stripped)
//  o_evt_ext    out  1  1 = E0-extended key
//  o_evt_break  out  1  1 = release, 0 = press
//  o_key_held   out  8  held bitmap: [0]Up [1]Down [2]Left [3]Right [4]Space [5]Enter [6]Esc [7]P
//  o_pause      out  1  one-cycle pulse on completed E1 Pause sequence
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, timeout counter 0, skip counter 0. i_rst wins over any input.
//  Byte strobe: new byte = rising edge of i_byte_done (registered copy); i_byte captured that cycle.
//   Level held high never produces a second byte. Done high during/at release of reset: no byte.
//  FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
//   IDLE: E0->EXT; F0->BRK; E1->SKIP (skip cnt=E1_SKIP); FA,AA,EE,00,FF dropped; else emit make.
//   EXT:  F0->EXT_BRK; 12 or 59 (fake shift) dropped->IDLE; else emit ext make->IDLE.
//   BRK:  emit break(code)->IDLE.  EXT_BRK: 12/59 dropped, else emit ext break ->IDLE.
//   SKIP: decrement per byte; on last byte pulse o_pause ->IDLE. No key events while in SKIP.
//   Prefix byte (E0/F0/E1) in a non-IDLE state other than the legal chain: restart from IDLE
//   interpretation of that byte (error recovery, partial sequence discarded).
//  Timeout: counter cleared on every byte; in any state != IDLE reaching TIMEOUT_CYC-1 with no
//   byte -> IDLE, no event. Counter saturates; held in 0 while IDLE.
//  Event latency: o_evt_valid high exactly 1 cycle, the cycle after the strobe of the final byte.
//   o_evt_code/ext/break hold their value until the next event.
//  Mapping (ext,code): Up(1,75) Down(1,72) Left(1,6B) Right(1,74) Space(0,29) Enter(0,5A)
//   Esc(0,76) P(0,4D). Mapped make sets bit, mapped break clears bit, same cycle as o_evt_valid.
//  Repeat suppression: make of a mapped key whose bit is already set emits no event.
//   Unmapped keys: every make emits an event (no state kept). Break of a non-held mapped key
//   still emits event (bit stays 0).
//  Extended vs plain with same code (e.g. 75 keypad-8 vs E0 75 Up) are distinct; only exact
//   (ext,code) pair affects the bitmap.
// STRUCTURE
//  Package ps2_pkg: state enum, prefix/status constants (E0,F0,E1,FA,AA,EE), key index enum,
//   mapping table function key_index(ext,code) -> {hit, idx[2:0]}.
//  Sub-module: edge_strobe (registered rising-edge detect on i_byte_done). Rest is one FSM.
// TESTING
//  Reset then bytes 1C -> evt code=1C ext=0 brk=0 one cycle; o_key_held=00.
//  E0 75, E0 75, E0 F0 75 -> one press evt, held=01 after press, release evt, held=00.
//  F0 29 with Space not held -> break evt code=29; held stays 00; no press evt.
//  E0 then no byte for TIMEOUT_CYC cycles, then 29 -> plain make code=29 ext=0, held=10.
//  E1 14 77 E1 F0 14 F0 77 -> o_pause pulse once, zero evt_valid pulses.
//  i_byte_done held high 50 cycles; FA, AA bytes; i_rst mid-E0 -> no spurious events, state IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_e;

    // Prefix and keyboard status bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_FA = 8'hFA;  // ack
    localparam logic [7:0] SC_AA = 8'hAA;  // self-test passed
    localparam logic [7:0] SC_EE = 8'hEE;  // echo
    localparam logic [7:0] SC_00 = 8'h00;  // buffer overrun
    localparam logic [7:0] SC_FF = 8'hFF;  // error
    // Fake shifts the keyboard wraps around some extended keys
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        KEY_UP    = 3'd0,
        KEY_DOWN  = 3'd1,
        KEY_LEFT  = 3'd2,
        KEY_RIGHT = 3'd3,
        KEY_SPACE = 3'd4,
        KEY_ENTER = 3'd5,
        KEY_ESC   = 3'd6,
        KEY_P     = 3'd7
    } key_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_E0) || (b == SC_F0) || (b == SC_E1);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == SC_LSHIFT) || (b == SC_RSHIFT);
    endfunction

    // Returns {hit, index} for the game-control keys; exact (ext,code) match only.
    function automatic logic [3:0] key_index(input logic ext, input logic [7:0] code);
        logic [3:0] r;
        r = 4'b0;
        case ({ext, code})
            9'h175: r = {1'b1, KEY_UP};
            9'h172: r = {1'b1, KEY_DOWN};
            9'h16B: r = {1'b1, KEY_LEFT};
            9'h174: r = {1'b1, KEY_RIGHT};
            9'h029: r = {1'b1, KEY_SPACE};
            9'h05A: r = {1'b1, KEY_ENTER};
            9'h076: r = {1'b1, KEY_ESC};
            9'h04D: r = {1'b1, KEY_P};
            default: r = 4'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/edge_strobe.sv
// Rising-edge detector on the receiver done level: one strobe per byte.
module edge_strobe (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_strobe
);

    logic level_q;

    // Previous level; forced high in reset so a level still high at release is not a new byte
    always_ff @(posedge i_clk) begin
        if (i_rst) level_q <= 1'b1;
        else       level_q <= i_level;
    end

    assign o_strobe = i_level & ~level_q & ~i_rst;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Scan-code set 2 decoder: prefix FSM, timeout, held-key bitmap, repeat suppression.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500_000,
    parameter int E1_SKIP     = 7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_done,
    output logic       o_evt_valid,
    output logic [7:0] o_evt_code,
    output logic       o_evt_ext,
    output logic       o_evt_break,
    output logic [7:0] o_key_held,
    output logic       o_pause
);

    localparam int TW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SKW = $clog2(E1_SKIP + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SKW-1:0] SKIP_INIT = SKW'(E1_SKIP);
    localparam logic [SKW-1:0] SKIP_ONE  = SKW'(1);

    logic strobe;

    state_e         state_q, state_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [SKW-1:0] skip_q, skip_d;
    logic           evt_valid_q, evt_valid_d;
    logic [7:0]     evt_code_q, evt_code_d;
    logic           evt_ext_q, evt_ext_d;
    logic           evt_brk_q, evt_brk_d;
    logic [7:0]     held_q, held_d;
    logic           pause_q, pause_d;

    // Decode scratch
    logic       emit, em_ext, em_brk, restart;
    logic [3:0] key;

    edge_strobe u_strobe (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_level  (i_byte_done),
        .o_strobe (strobe)
    );

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            skip_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            evt_ext_q   <= 1'b0;
            evt_brk_q   <= 1'b0;
            held_q      <= '0;
            pause_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            skip_q      <= skip_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_ext_q   <= evt_ext_d;
            evt_brk_q   <= evt_brk_d;
            held_q      <= held_d;
            pause_q     <= pause_d;
        end
    end

    // Next state: byte interpretation, timeout, event/bitmap update
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        skip_d      = skip_q;
        evt_valid_d = 1'b0;
        evt_code_d  = evt_code_q;
        evt_ext_d   = evt_ext_q;
        evt_brk_d   = evt_brk_q;
        held_d      = held_q;
        pause_d     = 1'b0;
        emit        = 1'b0;
        em_ext      = 1'b0;
        em_brk      = 1'b0;
        restart     = 1'b0;

        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: restart = 1'b1;
                ST_EXT: begin
                    if (i_byte == SC_F0)      state_d = ST_EXT_BRK;
                    else if (is_prefix(i_byte)) restart = 1'b1;
                    else begin
                        state_d = ST_IDLE;
                        emit    = ~is_fake_shift(i_byte);
                        em_ext  = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (is_prefix(i_byte)) restart = 1'b1;
                    else begin
                        state_d = ST_IDLE;
                        emit    = 1'b1;
                        em_brk  = 1'b1;
                    end
                end
                ST_EXT_BRK: begin
                    if (is_prefix(i_byte)) restart = 1'b1;
                    else begin
                        state_d = ST_IDLE;
                        emit    = ~is_fake_shift(i_byte);
                        em_ext  = 1'b1;
                        em_brk  = 1'b1;
                    end
                end
                ST_SKIP: begin
                    // Pause bytes are opaque, prefixes included
                    if (skip_q <= SKIP_ONE) begin
                        state_d = ST_IDLE;
                        skip_d  = '0;
                        pause_d = 1'b1;
                    end else begin
                        skip_d = skip_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Fresh interpretation; also used to recover from a broken prefix chain
            if (restart) begin
                state_d = ST_IDLE;
                case (i_byte)
                    SC_E0: state_d = ST_EXT;
                    SC_F0: state_d = ST_BRK;
                    SC_E1: begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_INIT;
                    end
                    SC_FA, SC_AA, SC_EE, SC_00, SC_FF: ;
                    default: emit = 1'b1;
                endcase
            end
        end else if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q >= TMO_LAST) begin
            // Abandon a stalled sequence silently; counter saturates until IDLE clears it
            state_d = ST_IDLE;
            skip_d  = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        key = key_index(em_ext, i_byte);
        if (emit && !(key[3] && !em_brk && held_q[key[2:0]])) begin
            evt_valid_d = 1'b1;
            evt_code_d  = i_byte;
            evt_ext_d   = em_ext;
            evt_brk_d   = em_brk;
            if (key[3]) held_d[key[2:0]] = ~em_brk;
        end
    end

    assign o_evt_valid = evt_valid_q;
    assign o_evt_code  = evt_code_q;
    assign o_evt_ext   = evt_ext_q;
    assign o_evt_break = evt_brk_q;
    assign o_key_held  = held_q;
    assign o_pause     = pause_q;

endmodule
